// File: rtl/restore_div40.sv
// 40-bit by DIV_W-bit restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define RESTORE_DIV40_SIGNED_EN for two's-complement operands (adds a one-cycle FIXUP state).
module restore_div40 #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [39:0]      dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [39:0]      quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and neither side queues.
`ifdef RESTORE_DIV40_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, FIXUP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state, state_next;
    logic [5:0]       cnt;
    logic [39:0]      q;
    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dsr;
    logic             dbz;
    logic [DIV_W:0]   trial;
    logic             take;
    logic [DIV_W-1:0] rem_nxt;
    logic             accept;
    logic [39:0]      dvd_mag;
    logic [DIV_W-1:0] dsr_mag;

`ifdef RESTORE_DIV40_SIGNED_EN
    logic q_neg, r_neg;
    assign dvd_mag = dividend[39] ? (~dividend + 40'd1) : dividend;
    assign dsr_mag = divisor[DIV_W-1] ? (~divisor + {{(DIV_W-1){1'b0}}, 1'b1}) : divisor;
`else
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
`endif

    assign accept    = in_valid && in_ready;
    assign trial     = {rem, q[39]};
    assign take      = trial >= {1'b0, dsr};
    // When take is set the difference is below dsr, so modular DIV_W-bit subtraction is exact.
    assign rem_nxt   = take ? (trial[DIV_W-1:0] - dsr) : trial[DIV_W-1:0];
    assign state_dbg = state;

    assign quotient    = q;
    assign remainder   = rem;
    assign div_by_zero = dbz;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (divisor == '0) ? DONE : BUSY;
`ifdef RESTORE_DIV40_SIGNED_EN
            BUSY:  if (cnt == 6'd0) state_next = FIXUP;
            FIXUP: state_next = DONE;
`else
            BUSY:  if (cnt == 6'd0) state_next = DONE;
`endif
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= 6'd0;
            q         <= 40'd0;
            rem       <= '0;
            dsr       <= '0;
            dbz       <= 1'b0;
`ifdef RESTORE_DIV40_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: if (accept) begin
                    cnt <= 6'd39;
                    dbz <= (divisor == '0);
                    if (divisor == '0) begin
                        q   <= '1;
                        rem <= dividend[DIV_W-1:0];
                        dsr <= '0;
                    end else begin
                        q   <= dvd_mag;
                        rem <= '0;
                        dsr <= dsr_mag;
                    end
`ifdef RESTORE_DIV40_SIGNED_EN
                    q_neg <= dividend[39] ^ divisor[DIV_W-1];
                    r_neg <= dividend[39];
`endif
                end
                BUSY: begin
                    q   <= {q[38:0], take};
                    rem <= rem_nxt;
                    cnt <= cnt - 6'd1;
                end
`ifdef RESTORE_DIV40_SIGNED_EN
                FIXUP: begin
                    if (q_neg) q <= ~q + 40'd1;
                    if (r_neg) rem <= ~rem + {{(DIV_W-1){1'b0}}, 1'b1};
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restore_div40.sv
// Directed bench for restore_div40: hand-computed vectors, backpressure, zero divisor, mid-run reset.
module tb_restore_div40;
    localparam int W = 16;
`ifdef RESTORE_DIV40_SIGNED_EN
    localparam int LAT = 41;
`else
    localparam int LAT = 40;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [39:0]   dividend = 40'd0;
    logic [W-1:0]  divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [39:0]   quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    logic [40+W:0] exp_q[$];

    restore_div40 #(.DIV_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_quotient"}, 64'(quotient), 64'd0);
        check({tag, "_remainder"}, 64'(remainder), 64'd0);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    endtask

    task automatic start_op(input logic [39:0] a, input logic [W-1:0] b,
                            input logic [39:0] eq, input logic [W-1:0] er, input logic edbz);
        exp_q.push_back({eq, er, edbz});
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = {8'($urandom_range(0, 255)), 32'($urandom)};
        divisor  = W'($urandom_range(1, 65535));
    endtask

    task automatic wait_result(input string tag, input int lat_exp);
        int lat;
        logic [40+W:0] e;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_quotient"}, 64'(quotient), 64'(e[40+W:W+1]));
        check({tag, "_remainder"}, 64'(remainder), 64'(e[W:1]));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(e[0]));
    endtask

    task automatic release_result(input string tag);
        logic [39:0] q_hold;
        q_hold = quotient;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, "_quotient_kept"}, 64'(quotient), 64'(q_hold));
    endtask

    task automatic run(input string tag, input logic [39:0] a, input logic [W-1:0] b,
                       input logic [39:0] eq, input logic [W-1:0] er, input logic edbz,
                       input int lat_exp);
        start_op(a, b, eq, er, edbz);
        wait_result(tag, lat_exp);
        release_result(tag);
    endtask

    initial begin
        // Reset state
        #2;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_first_edge", 64'(in_ready), 64'd1);

        run("u100_7", 40'd100, 16'd7, 40'd14, 16'd2, 1'b0, LAT);
        run("all_ones_by_1", 40'hFF_FFFF_FFFF, 16'd1, 40'hFF_FFFF_FFFF, 16'd0, 1'b0, LAT);
        run("div_zero", 40'h12_3456_789A, 16'd0, 40'hFF_FFFF_FFFF, 16'h789A, 1'b1, 1);
        run("eq_1000", 40'd1000, 16'd1000, 40'd1, 16'd0, 1'b0, LAT);
        run("small_7_9", 40'd7, 16'd9, 40'd0, 16'd7, 1'b0, LAT);
`ifdef RESTORE_DIV40_SIGNED_EN
        run("s5_m1", 40'd5, 16'hFFFF, 40'hFF_FFFF_FFFB, 16'd0, 1'b0, LAT);
        run("sm100_7", 40'hFF_FFFF_FF9C, 16'd7, 40'hFF_FFFF_FFF2, 16'hFFFE, 1'b0, LAT);
        run("s100_m7", 40'd100, 16'hFFF9, 40'hFF_FFFF_FFF2, 16'd2, 1'b0, LAT);
        run("smin_m1", 40'h80_0000_0000, 16'hFFFF, 40'h80_0000_0000, 16'd0, 1'b0, LAT);
`else
        run("u5_ffff", 40'd5, 16'hFFFF, 40'd0, 16'd5, 1'b0, LAT);
`endif

        // Backpressure: result held, new requests ignored
        start_op(40'd1000, 16'd3, 40'd333, 16'd1, 1'b0);
        wait_result("bp", LAT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            dividend = 40'd77;
            divisor  = 16'd5;
            @(posedge clk);
            #1;
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
            check("bp_quotient_held", 64'(quotient), 64'd333);
            check("bp_remainder_held", 64'(remainder), 64'd1);
        end
        in_valid = 1'b0;
        release_result("bp");
        @(posedge clk);
        #1;
        check("bp_no_spurious_start", 64'(in_ready), 64'd1);

        // Reset mid-computation aborts the operation
        start_op(40'd1000, 16'd3, 40'd0, 16'd0, 1'b0);
        void'(exp_q.pop_back());
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        run("after_rst_9_2", 40'd9, 16'd2, 40'd4, 16'd1, 1'b0, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/restore_div40.md
RESTORE_DIV40 -- requirements
Module: restore_div40

Interface
REQ-001 SHALL have parameter DIV_W, default 16: divisor and remainder width, 2..39.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1: operands present.
REQ-005 SHALL have port in_ready, output, 1: block idle and able to accept.
REQ-006 SHALL have port dividend, input, 40: dividend, unsigned unless REQ-026 applies.
REQ-007 SHALL have port divisor, input, DIV_W: divisor.
REQ-008 SHALL have port out_valid, output, 1: result present.
REQ-009 SHALL have port out_ready, input, 1: consumer takes result.
REQ-010 SHALL have port quotient, output, 40: quotient.
REQ-011 SHALL have port remainder, output, DIV_W: remainder.
REQ-012 SHALL have port div_by_zero, output, 1: the current result came from a zero divisor.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE, plus FIXUP when REQ-026 applies.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL accept operands on a rising edge where in_valid and in_ready are both high.
REQ-016 SHALL sample dividend and divisor only on the accepting edge; input changes at any other time have no effect.
REQ-017 SHALL ignore in_valid outside IDLE; there is no queueing.
REQ-018 On accept with a nonzero divisor, SHALL enter BUSY and perform 40 restoring iterations, one per cycle, dividend MSB first.
REQ-019 Each iteration SHALL form a (DIV_W+1)-bit trial remainder {rem, next dividend bit} and compare it against the divisor.
REQ-020 Each iteration SHALL subtract the divisor and shift in quotient bit 1 if the trial remainder is >= divisor; otherwise it SHALL keep the trial remainder and shift in 0.
REQ-021 SHALL use a 6-bit iteration counter loaded with 39 and decremented each iteration; the transition to DONE occurs on the iteration where the counter is 0.
REQ-022 SHALL assert out_valid exactly 40 rising edges after the accepting edge (unsigned build).
REQ-023 On accept with divisor == 0, SHALL go directly to DONE with out_valid asserted 1 edge after accept, quotient = all ones, remainder = dividend[DIV_W-1:0] and div_by_zero = 1; div_by_zero SHALL be 0 for every other result.
REQ-024 In DONE, SHALL hold quotient, remainder and div_by_zero stable while out_valid is high and out_ready is low.
REQ-025 On an edge where out_valid and out_ready are both high, SHALL return to IDLE, deassert out_valid and assert in_ready on that same edge; outputs retain their last values.

Configuration
REQ-026 With macro RESTORE_DIV40_SIGNED_EN defined, dividend and divisor SHALL be two's complement; the block divides magnitudes, then passes through FIXUP for one cycle, so out_valid asserts 41 edges after accept.
REQ-027 In FIXUP, SHALL negate the quotient when the operand signs differ, give the remainder the sign of the dividend, and truncate toward zero.
REQ-028 In the signed build, -2^39 / -1 SHALL yield quotient 0x80_0000_0000 (wrap) with remainder 0.
REQ-029 In the signed build, a zero divisor SHALL produce the REQ-023 result unchanged.
REQ-030 Without RESTORE_DIV40_SIGNED_EN, operands SHALL be unsigned, no FIXUP state exists, and latency is per REQ-022.

Reset
REQ-031 While rst_n is low, SHALL force state IDLE, in_ready 0, out_valid 0, quotient 0, remainder 0, div_by_zero 0, and clear the counter and working registers.
REQ-032 SHALL assert in_ready on the first rising edge after rst_n deasserts.
REQ-033 Reset asserted in BUSY, FIXUP or DONE SHALL abort the operation without producing a result.

Verification
REQ-034 Unsigned: dividend 100, divisor 7 -> quotient 14, remainder 2, out_valid exactly 40 edges after accept, div_by_zero 0.
REQ-035 Unsigned: dividend 0xFF_FFFF_FFFF, divisor 1 -> quotient 0xFF_FFFF_FFFF, remainder 0; dividend 5, divisor 0xFFFF -> quotient 0, remainder 5.
REQ-036 Divisor 0 with dividend 0x12_3456_789A -> out_valid 1 edge after accept, quotient all ones, remainder 0x789A, div_by_zero 1.
REQ-037 Backpressure: out_ready held low 5 cycles after out_valid -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready high -> in_ready high on the same edge.
REQ-038 Reset pulse at iteration 20 of 1000/3 -> all outputs 0, in_ready 1 one edge after release; a new 9/2 then gives quotient 4, remainder 1.
REQ-039 Signed build: -100/7 -> quotient -14, remainder -2, latency 41; 100/-7 -> quotient -14, remainder 2; -2^39/-1 -> quotient 0x80_0000_0000.
